// File: rtl/hazard_md_ctrl.sv
// Pipeline stall controller: Tuse/Tnew dependency stalls plus occupancy of the
// multi-cycle mult/div unit, with a small sequencer tracking the busy window.
module hazard_md_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [2:0] Tuse_rs,
   input  logic [2:0] Tuse_rt,
   input  logic       md_D,
   input  logic [4:0] A3_E,
   input  logic       GRFWE_E,
   input  logic [2:0] Tnew_E,
   input  logic [4:0] A3_M,
   input  logic       GRFWE_M,
   input  logic [2:0] Tnew_M,
   input  logic       start_E,
   input  logic [1:0] md_op_E,
   output logic       stall,
   output logic       en_PC,
   output logic       en_FD,
   output logic       clr_DE,
   output logic       md_busy,
   output logic       md_done,
   output logic [1:0] md_op,
   output logic       err_restart
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic [CNT_W-1:0] w_launch_cnt;
   logic [1:0]       r_md_op;
   logic [1:0]       w_md_op_next;
   logic             r_err;
   logic             w_err_next;

   // Operand 0 is rs, operand 1 is rt; both are checked against E and M.
   logic [4:0] w_src_reg  [2];
   logic [2:0] w_src_tuse [2];
   logic       w_src_stall[2];
   logic       w_stall_md;
   logic       w_stall;

   assign w_src_reg[0]  = rs_D;
   assign w_src_reg[1]  = rt_D;
   assign w_src_tuse[0] = Tuse_rs;
   assign w_src_tuse[1] = Tuse_rt;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dep
         logic w_hit_E;
         logic w_hit_M;
         assign w_hit_E = GRFWE_E && (A3_E == w_src_reg[gi]) && (w_src_tuse[gi] < Tnew_E);
         assign w_hit_M = GRFWE_M && (A3_M == w_src_reg[gi]) && (w_src_tuse[gi] < Tnew_M);
         assign w_src_stall[gi] = (w_src_reg[gi] != 5'd0) && (w_hit_E || w_hit_M);
      end
   endgenerate

   // The start cycle itself also blocks a D-stage md instruction.
   assign w_stall_md = md_D && (start_E || (r_state == S_BUSY));
   assign w_stall    = w_src_stall[0] || w_src_stall[1] || w_stall_md;

   assign stall  = w_stall;
   assign en_PC  = ~w_stall;
   assign en_FD  = ~w_stall;
   assign clr_DE = w_stall;

   // Count is loaded with cycles-1 so it reads 0 in the last busy cycle.
   assign w_launch_cnt = md_op_E[1] ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_md_op <= 2'b00;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_md_op <= w_md_op_next;
         r_err   <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_md_op_next = r_md_op;
      w_err_next   = r_err;
      case (r_state)
         S_IDLE: begin
            if (start_E) begin
               w_state_next = S_BUSY;
               w_count_next = w_launch_cnt;
               w_md_op_next = md_op_E;
            end
         end
         S_BUSY: begin
            // A start here is illegal; it is flagged but never disturbs the run.
            if (start_E) begin
               w_err_next = 1'b1;
            end
            if (r_count == '0) begin
               w_state_next = S_DONE;
            end else begin
               w_count_next = r_count - 1'b1;
            end
         end
         S_DONE: begin
            if (start_E) begin
               w_state_next = S_BUSY;
               w_count_next = w_launch_cnt;
               w_md_op_next = md_op_E;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_count_next = '0;
         end
      endcase
   end

   assign md_busy     = (r_state == S_BUSY);
   assign md_done     = (r_state == S_DONE);
   assign md_op       = r_md_op;
   assign err_restart = r_err;

endmodule

// File: doc/hazard_md_ctrl.md
Name: hazard_md_ctrl

Overview:
Pipeline stall controller for the 5-stage MIPS core. It generates the F/D/E register enables and the D/E bubble insertion, combining two stall sources:
- Tuse/Tnew register-dependency hazards.
- Occupancy of the multi-cycle mult/div unit.

It holds a small sequencer that models the mult/div busy window. It sits between the decode logic, the D/E and E/M pipeline registers, and the mult/div unit.

Parameters:
MULT_CYC, 5, cycles mult/multu occupies the unit after start
DIV_CYC, 10, cycles div/divu occupies the unit after start
CNT_W, 4, busy counter width; must hold max(MULT_CYC, DIV_CYC)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
rs_D  in  5  rs field of instruction in D
rt_D  in  5  rt field of instruction in D
Tuse_rs  in  3  cycles until D instruction needs rs (7 = never)
Tuse_rt  in  3  cycles until D instruction needs rt (7 = never)
md_D  in  1  D instruction accesses mult/div unit (mult/div/mfhi/mflo/mthi/mtlo)
A3_E  in  5  destination register of E instruction
GRFWE_E  in  1  E instruction writes GRF
Tnew_E  in  3  cycles until E result is available
A3_M  in  5  destination register of M instruction
GRFWE_M  in  1  M instruction writes GRF
Tnew_M  in  3  cycles until M result is available
start_E  in  1  E instruction is mult/multu/div/divu (unit launches this cycle)
md_op_E  in  2  00 mult, 01 multu, 10 div, 11 divu
stall  out  1  combined stall indication
en_PC  out  1  PC enable (= ~stall)
en_FD  out  1  F/D register enable (= ~stall)
clr_DE  out  1  synchronous clear of D/E register, inserts bubble (= stall)
md_busy  out  1  mult/div unit occupied
md_done  out  1  one-cycle pulse; HI/LO result valid this cycle
md_op  out  2  latched op of running/completed operation
err_restart  out  1  sticky; set if start_E asserted while md_busy

Behaviour:
Reset:
- reset=0 at any time asynchronously forces state IDLE, count 0, md_busy 0, md_done 0, md_op 00, err_restart 0.
- Outputs derived from state follow immediately.
- Reset mid-operation abandons the operation; no md_done is produced.

Dependency stall (combinational):
- stall_rs = (rs_D != 0) and [(GRFWE_E and A3_E == rs_D and Tuse_rs < Tnew_E) or (GRFWE_M and A3_M == rs_D and Tuse_rs < Tnew_M)].
- stall_rt is the same with rt_D and Tuse_rt.
- Register $0 never stalls.
- Tuse 7 never stalls, since Tnew ≤ 3.

Mult/div stall (combinational):
- stall_md = md_D and (start_E or md_busy).
- stall = stall_rs or stall_rt or stall_md.
- en_PC = en_FD = ~stall; clr_DE = stall.

Sequencer states: IDLE, BUSY, DONE.
- IDLE: start_E=1 → BUSY; count ← (md_op_E[1] ? DIV_CYC : MULT_CYC) - 1; md_op ← md_op_E.
- BUSY: count decrements each cycle. When count == 0 at a clock edge → DONE.
- DONE: lasts exactly one cycle, md_done=1. Next state is IDLE, or BUSY if start_E=1 (back-to-back start accepted, new op latched).
- md_busy = 1 in BUSY, 0 in IDLE and DONE. The D instruction sees HI/LO valid in the DONE cycle and is not stalled by the unit there.
- A start from IDLE at edge t: md_busy is high for exactly MULT_CYC (resp. DIV_CYC) cycles, then md_done pulses in the following cycle.
- start_E while BUSY: ignored, count undisturbed, err_restart set sticky until reset. This cannot occur legally, because stall_md prevents it.

Arithmetic: count is unsigned CNT_W bits; it never wraps, since decrement is gated at 0.

Simultaneous events: a dependency stall and an md stall in the same cycle give a single stall; priority is irrelevant because the outputs are OR-combined.

Test Plan:
1. reset=0 mid-BUSY (count=3) → md_busy=0, state IDLE immediately; no md_done after release; err_restart=0.
2. lw $1 in E (GRFWE_E=1, A3_E=1, Tnew_E=2), D add using rs=1, Tuse_rs=1 → stall=1, clr_DE=1, en_PC=0. With Tnew_E=1 → stall=0.
3. Same as scenario 2 but A3_E=0, rs_D=0 → stall=0.
4. start_E=1, md_op_E=00 at edge t → md_busy=1 for 5 cycles, md_done=1 in 6th cycle, md_op=00. mfhi in D (md_D=1) stalls during start and busy cycles, released in the done cycle.
5. div start (md_op_E=10) → md_busy for 10 cycles. A second start_E in the DONE cycle → new BUSY run of 10 cycles, md_done again; err_restart stays 0.
6. Force start_E=1 while BUSY at count=4 → count continues 3,2,1,0, md_done on schedule, err_restart=1 and stays high until reset.
